exe_stage_muldiv: RTL and testbench
===================================

Name: exe_stage_muldiv

Overview:
Execute stage placed directly downstream of the ID/EXE pipeline register. It consumes the decoded command and operands and produces the EXE/MEM register contents. Single-cycle ALU operations complete in 1 cycle. Unsigned MUL, DIV and REM run on an iterative 32-step shared unit, which raises Stall to freeze the upstream stages until the result is available.

Parameters:
- WIDTH, 32, datapath width; the iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- Flush  in  1  kill the current instruction; abort any iterative operation
- WB_EN_EXE  in  1  writeback enable from ID/EXE register
- MEM_CMD_EXE  in  2  memory command (0 = none)
- EXE_CMD_EXE  in  6  execute command
- PC  in  32  instruction PC
- Val1_EXE  in  32  operand A
- Val2_EXE  in  32  operand B / shift amount
- Reg2_EXE  in  32  store data
- Dst_EXE  in  5  destination register
- Stall  out  1  combinational; freeze PC, IF/ID and ID/EXE while 1
- WB_EN_MEM  out  1  registered writeback enable
- MEM_CMD_MEM  out  2  registered memory command
- ALU_Res_MEM  out  32  registered result or address
- Reg2_MEM  out  32  registered store data
- Dst_MEM  out  5  registered destination register
- PC_MEM  out  32  registered PC

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, the FSM is in IDLE, and the counter is 0. Stall is 0 while in reset.
- Commands (from package):
  - ADD=0, SUB=1, AND=2, OR=3, NOR=4, XOR=5, SLL=6, SRL=7, SRA=8, MUL=9, DIV=10, REM=11.
  - Any other code behaves as ADD.
  - Shift amount is Val2_EXE[4:0].
  - All arithmetic is modulo 2^32, with no overflow flag.
- ALU path, IDLE state with a non-muldiv command:
  - Outputs load on the next edge: 1-cycle latency.
  - ALU_Res_MEM gets the ALU result. All other outputs pass through unchanged.
- FSM states: IDLE, RUN, DONE.
- IDLE with MUL, DIV or REM at the input (cycle T), and Flush=0:
  - Stall=1 in cycle T (combinational).
  - Operands and op are latched, counter is 0, next state is RUN.
  - Output regs load a bubble: WB_EN_MEM=0, MEM_CMD_MEM=0, other outputs 0.
- RUN (cycles T+1 to T+32):
  - One iteration per edge; Stall=1; bubble is loaded each edge.
  - MUL: shift-add algorithm; keep the low 32 bits.
  - DIV/REM: restoring algorithm.
  - When the counter reaches 31, next state is DONE.
- DONE (cycle T+33):
  - Stall=0. The held instruction is still at the input and is consumed here; it is not restarted.
  - Output regs load the quotient, remainder or product, plus the held WB/MEM/Dst/PC/Reg2. Next state is IDLE.
  - Total: 33 stall cycles; result is visible after the edge that ends cycle T+33.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = dividend. The restoring algorithm produces this naturally.
- Flush in any state: next state is IDLE, the counter clears, and a bubble is loaded. Stall=0 in the cycle where Flush=1. Flush has priority over starting a new operation.
- Reset mid-operation: immediate return to the reset values; any partial result is discarded.
- The input seen by DONE is guaranteed equal to the one captured in T because upstream is frozen. The latched copy is used; inputs are not re-read.

Optional Feature:
- Macro: EXE_SIGNED_MULDIV_EN.
- Defined: adds DIVS=12 and REMS=13.
  - Absolute values are fed to the shared unit. The quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
  - Signed divide by zero gives quotient -1 and remainder = dividend.
  - Latency is unchanged.
- Undefined: codes 12 and 13 behave as ADD.

Decomposition:
- Package exe_pkg holds:
  - EXE_CMD_* localparams (6-bit)
  - MEM_CMD_* codes
  - FSM state encoding (2-bit)
  - WIDTH default
- Sub-module iter_muldiv holds the FSM-free datapath:
  - operand registers, accumulator and remainder, counter
  - interface: start, op, a, b → done_pulse, result
- The top module holds the FSM, ALU, Stall and the EXE/MEM output registers.

Test Plan:
- Reset: rst=0 during a running DIV → all outputs 0 and Stall=0 immediately. After release, ADD 3+4 → ALU_Res_MEM=7 after 1 edge.
- ALU ops:
  - SUB 5-7 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - NOR 0,0 → 0xFFFFFFFF.
  - Each with 1-cycle latency and WB_EN passed through.
- MUL 0x0001_0003 × 0x0000_0005:
  - Stall high for exactly 33 cycles; bubbles (WB_EN_MEM=0) during the stall.
  - Result 0x0005_000F with Dst_MEM = the held Dst.
  - Next ADD issued back-to-back completes 1 cycle later.
- DIV/REM 100/7 → 14, REM → 2. DIV 9/0 → 0xFFFFFFFF, REM 9/0 → 9.
- Flush at RUN cycle 10 → Stall drops that cycle, bubble loaded, FSM in IDLE. The next MUL 2×3 → 6 with full latency.
- With EXE_SIGNED_MULDIV_EN: DIVS -7/2 → -3, REMS → -1; 0x80000000 / -1 → 0x80000000. Without the macro, code 12 with 1,2 → 3.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: command codes, memory commands,
// FSM states and the iterative-unit operation select.
package exe_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] EXE_CMD_ADD  = 6'd0;
  localparam logic [5:0] EXE_CMD_SUB  = 6'd1;
  localparam logic [5:0] EXE_CMD_AND  = 6'd2;
  localparam logic [5:0] EXE_CMD_OR   = 6'd3;
  localparam logic [5:0] EXE_CMD_NOR  = 6'd4;
  localparam logic [5:0] EXE_CMD_XOR  = 6'd5;
  localparam logic [5:0] EXE_CMD_SLL  = 6'd6;
  localparam logic [5:0] EXE_CMD_SRL  = 6'd7;
  localparam logic [5:0] EXE_CMD_SRA  = 6'd8;
  localparam logic [5:0] EXE_CMD_MUL  = 6'd9;
  localparam logic [5:0] EXE_CMD_DIV  = 6'd10;
  localparam logic [5:0] EXE_CMD_REM  = 6'd11;
  localparam logic [5:0] EXE_CMD_DIVS = 6'd12;
  localparam logic [5:0] EXE_CMD_REMS = 6'd13;

  localparam logic [1:0] MEM_CMD_NONE  = 2'd0;
  localparam logic [1:0] MEM_CMD_LOAD  = 2'd1;
  localparam logic [1:0] MEM_CMD_STORE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } exe_state_t;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_t;

  function automatic logic is_muldiv(input logic [5:0] cmd);
    logic r;
    r = (cmd == EXE_CMD_MUL) || (cmd == EXE_CMD_DIV) || (cmd == EXE_CMD_REM);
`ifdef EXE_SIGNED_MULDIV_EN
    r = r || (cmd == EXE_CMD_DIVS) || (cmd == EXE_CMD_REMS);
`endif
    return r;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-bit-per-step unsigned multiply (shift-add) and divide (restoring).
// acc holds product/remainder, opa holds multiplicand/dividend-then-quotient.
module iter_muldiv
  import exe_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         start,
  input  logic         step,
  input  md_op_t       op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done_pulse,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] cnt;
  md_op_t        op_q;
  logic [W-1:0]  acc;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W:0]    trial;
  logic [W:0]    diff;

  assign trial      = {acc, opa[W-1]};
  assign diff       = trial - {1'b0, opb};
  assign done_pulse = step && (cnt == CW'(W - 1));
  assign result     = (op_q == MD_DIV) ? opa : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      op_q <= MD_MUL;
      acc  <= '0;
      opa  <= '0;
      opb  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt  <= '0;
      op_q <= op;
      acc  <= '0;
      opa  <= a;
      opb  <= b;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (op_q == MD_MUL) begin
        if (opb[0]) acc <= acc + opa;
        opa <= {opa[W-2:0], 1'b0};
        opb <= {1'b0, opb[W-1:1]};
      end else if (trial >= {1'b0, opb}) begin
        // A zero divisor always subtracts: quotient all ones, remainder = dividend.
        acc <= diff[W-1:0];
        opa <= {opa[W-2:0], 1'b1};
      end else begin
        acc <= trial[W-1:0];
        opa <= {opa[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/exe_stage_muldiv.sv
// Execute stage: 1-cycle ALU plus a 32-step iterative MUL/DIV/REM that holds Stall.
// Optional macro EXE_SIGNED_MULDIV_EN adds signed DIVS/REMS.
module exe_stage_muldiv
  import exe_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Flush,
  input  logic         WB_EN_EXE,
  input  logic [1:0]   MEM_CMD_EXE,
  input  logic [5:0]   EXE_CMD_EXE,
  input  logic [31:0]  PC,
  input  logic [W-1:0] Val1_EXE,
  input  logic [W-1:0] Val2_EXE,
  input  logic [W-1:0] Reg2_EXE,
  input  logic [4:0]   Dst_EXE,
  output logic         Stall,
  output logic         WB_EN_MEM,
  output logic [1:0]   MEM_CMD_MEM,
  output logic [W-1:0] ALU_Res_MEM,
  output logic [W-1:0] Reg2_MEM,
  output logic [4:0]   Dst_MEM,
  output logic [31:0]  PC_MEM,
  output exe_state_t   state_dbg
);

  // Stall=1 means the instruction at the input is not consumed this cycle and
  // upstream must hold it unchanged; the EXE/MEM registers receive a bubble.
  exe_state_t   state, state_nxt;
  logic         stall_c, md_start, md_step, md_clear, md_done;
  logic [W-1:0] alu_res, md_raw, md_res, md_a, md_b;
  md_op_t       md_op;
  logic         md_neg;

  logic         h_wb, h_neg;
  logic [1:0]   h_mem;
  logic [4:0]   h_dst;
  logic [31:0]  h_pc;
  logic [W-1:0] h_reg2;

  logic         n_wb;
  logic [1:0]   n_mem;
  logic [W-1:0] n_res, n_reg2;
  logic [4:0]   n_dst;
  logic [31:0]  n_pc;

  assign state_dbg = state;
  assign Stall     = rst & stall_c;

  always_comb begin
    alu_res = Val1_EXE + Val2_EXE;
    case (EXE_CMD_EXE)
      EXE_CMD_SUB: alu_res = Val1_EXE - Val2_EXE;
      EXE_CMD_AND: alu_res = Val1_EXE & Val2_EXE;
      EXE_CMD_OR:  alu_res = Val1_EXE | Val2_EXE;
      EXE_CMD_NOR: alu_res = ~(Val1_EXE | Val2_EXE);
      EXE_CMD_XOR: alu_res = Val1_EXE ^ Val2_EXE;
      EXE_CMD_SLL: alu_res = Val1_EXE << Val2_EXE[4:0];
      EXE_CMD_SRL: alu_res = Val1_EXE >> Val2_EXE[4:0];
      EXE_CMD_SRA: alu_res = W'($signed(Val1_EXE) >>> Val2_EXE[4:0]);
      default:     alu_res = Val1_EXE + Val2_EXE;
    endcase
  end

  always_comb begin
    md_op  = MD_MUL;
    md_a   = Val1_EXE;
    md_b   = Val2_EXE;
    md_neg = 1'b0;
    if (EXE_CMD_EXE == EXE_CMD_DIV) md_op = MD_DIV;
    if (EXE_CMD_EXE == EXE_CMD_REM) md_op = MD_REM;
`ifdef EXE_SIGNED_MULDIV_EN
    if (EXE_CMD_EXE == EXE_CMD_DIVS || EXE_CMD_EXE == EXE_CMD_REMS) begin
      md_a = Val1_EXE[W-1] ? -Val1_EXE : Val1_EXE;
      md_b = Val2_EXE[W-1] ? -Val2_EXE : Val2_EXE;
      if (EXE_CMD_EXE == EXE_CMD_DIVS) begin
        md_op  = MD_DIV;
        // Divide by zero keeps the all-ones quotient as -1.
        md_neg = (Val1_EXE[W-1] ^ Val2_EXE[W-1]) && (Val2_EXE != '0);
      end else begin
        md_op  = MD_REM;
        md_neg = Val1_EXE[W-1];
      end
    end
`endif
  end

  assign md_res = h_neg ? -md_raw : md_raw;

  iter_muldiv #(.W(W)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .clear      (md_clear),
    .start      (md_start),
    .step       (md_step),
    .op         (md_op),
    .a          (md_a),
    .b          (md_b),
    .done_pulse (md_done),
    .result     (md_raw)
  );

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    md_start  = 1'b0;
    md_step   = 1'b0;
    md_clear  = 1'b0;
    n_wb      = 1'b0;
    n_mem     = MEM_CMD_NONE;
    n_res     = '0;
    n_reg2    = '0;
    n_dst     = '0;
    n_pc      = '0;
    if (Flush) begin
      state_nxt = ST_IDLE;
      md_clear  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_muldiv(EXE_CMD_EXE)) begin
            stall_c   = 1'b1;
            md_start  = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            n_wb   = WB_EN_EXE;
            n_mem  = MEM_CMD_EXE;
            n_res  = alu_res;
            n_reg2 = Reg2_EXE;
            n_dst  = Dst_EXE;
            n_pc   = PC;
          end
        end
        ST_RUN: begin
          stall_c = 1'b1;
          md_step = 1'b1;
          if (md_done) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          n_wb      = h_wb;
          n_mem     = h_mem;
          n_res     = md_res;
          n_reg2    = h_reg2;
          n_dst     = h_dst;
          n_pc      = h_pc;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      WB_EN_MEM   <= 1'b0;
      MEM_CMD_MEM <= '0;
      ALU_Res_MEM <= '0;
      Reg2_MEM    <= '0;
      Dst_MEM     <= '0;
      PC_MEM      <= '0;
      h_wb        <= 1'b0;
      h_neg       <= 1'b0;
      h_mem       <= '0;
      h_dst       <= '0;
      h_pc        <= '0;
      h_reg2      <= '0;
    end else begin
      state       <= state_nxt;
      WB_EN_MEM   <= n_wb;
      MEM_CMD_MEM <= n_mem;
      ALU_Res_MEM <= n_res;
      Reg2_MEM    <= n_reg2;
      Dst_MEM     <= n_dst;
      PC_MEM      <= n_pc;
      if (md_start) begin
        h_wb   <= WB_EN_EXE;
        h_neg  <= md_neg;
        h_mem  <= MEM_CMD_EXE;
        h_dst  <= Dst_EXE;
        h_pc   <= PC;
        h_reg2 <= Reg2_EXE;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Directed bench for exe_stage_muldiv: ALU ops, iterative MUL/DIV/REM, flush, reset.
module tb_exe_stage_muldiv;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush;
  logic        WB_EN_EXE;
  logic [1:0]  MEM_CMD_EXE;
  logic [5:0]  EXE_CMD_EXE;
  logic [31:0] PC, Val1_EXE, Val2_EXE, Reg2_EXE;
  logic [4:0]  Dst_EXE;
  logic        Stall, WB_EN_MEM;
  logic [1:0]  MEM_CMD_MEM;
  logic [31:0] ALU_Res_MEM, Reg2_MEM, PC_MEM;
  logic [4:0]  Dst_MEM;
  exe_state_t  state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_stage_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .Flush       (Flush),
    .WB_EN_EXE   (WB_EN_EXE),
    .MEM_CMD_EXE (MEM_CMD_EXE),
    .EXE_CMD_EXE (EXE_CMD_EXE),
    .PC          (PC),
    .Val1_EXE    (Val1_EXE),
    .Val2_EXE    (Val2_EXE),
    .Reg2_EXE    (Reg2_EXE),
    .Dst_EXE     (Dst_EXE),
    .Stall       (Stall),
    .WB_EN_MEM   (WB_EN_MEM),
    .MEM_CMD_MEM (MEM_CMD_MEM),
    .ALU_Res_MEM (ALU_Res_MEM),
    .Reg2_MEM    (Reg2_MEM),
    .Dst_MEM     (Dst_MEM),
    .PC_MEM      (PC_MEM),
    .state_dbg   (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic wb, input logic [4:0] dst, input logic [31:0] pc);
    EXE_CMD_EXE = cmd;
    Val1_EXE    = a;
    Val2_EXE    = b;
    WB_EN_EXE   = wb;
    MEM_CMD_EXE = 2'd1;
    Dst_EXE     = dst;
    PC          = pc;
    Reg2_EXE    = pc ^ 32'h5a5a_0000;
  endtask

  task automatic set_nop;
    set_in(EXE_CMD_ADD, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    MEM_CMD_EXE = 2'd0;
    Reg2_EXE    = 32'd0;
  endtask

  task automatic alu_test(input string tag, input logic [5:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [4:0]  dst;
    logic [31:0] pc;
    dst = 5'($urandom_range(1, 31));
    pc  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    set_in(cmd, a, b, 1'b1, dst, pc);
    #1;
    chk({tag, ".stall"}, 32'(Stall), 32'd0);
    tick;
    chk(tag, ALU_Res_MEM, exp);
    chk({tag, ".wb"}, 32'(WB_EN_MEM), 32'd1);
    chk({tag, ".mem"}, 32'(MEM_CMD_MEM), 32'd1);
    chk({tag, ".dst"}, 32'(Dst_MEM), 32'(dst));
    chk({tag, ".pc"}, PC_MEM, pc);
    chk({tag, ".reg2"}, Reg2_MEM, pc ^ 32'h5a5a_0000);
  endtask

  task automatic md_test(input string tag, input logic [5:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    int bub;
    n   = 0;
    bub = 0;
    set_in(cmd, a, b, 1'b1, 5'd9, 32'h0000_0100);
    #1;
    while (Stall && n < 40) begin
      tick;
      n++;
      if (Stall && (WB_EN_MEM !== 1'b0 || ALU_Res_MEM !== 32'd0 || Dst_MEM !== 5'd0)) bub++;
    end
    chk({tag, ".stalls"}, 32'(n), 32'd33);
    chk({tag, ".bubble"}, 32'(bub), 32'd0);
    tick;
    chk(tag, ALU_Res_MEM, exp);
    chk({tag, ".wb"}, 32'(WB_EN_MEM), 32'd1);
    chk({tag, ".dst"}, 32'(Dst_MEM), 32'd9);
    chk({tag, ".pc"}, PC_MEM, 32'h0000_0100);
    set_nop;
  endtask

  initial begin
    Flush = 1'b0;
    rst   = 1'b0;
    set_in(EXE_CMD_DIV, 32'd5, 32'd1, 1'b1, 5'd3, 32'h10);
    tick;
    tick;
    #1;
    chk("rst.stall", 32'(Stall), 32'd0);
    chk("rst.wb", 32'(WB_EN_MEM), 32'd0);
    chk("rst.res", ALU_Res_MEM, 32'd0);
    chk("rst.state", 32'(state_dbg), 32'(ST_IDLE));
    set_nop;
    rst = 1'b1;
    tick;

    alu_test("add", EXE_CMD_ADD, 32'd3, 32'd4, 32'd7);
    alu_test("sub", EXE_CMD_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_test("sra", EXE_CMD_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_test("nor", EXE_CMD_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF);
    alu_test("and", EXE_CMD_AND, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034);
    alu_test("or", EXE_CMD_OR, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011);
    alu_test("xor", EXE_CMD_XOR, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA);
    alu_test("sll", EXE_CMD_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000);
    alu_test("srl", EXE_CMD_SRL, 32'h8000_0000, 32'd31, 32'd1);
    alu_test("cmd63", 6'd63, 32'd10, 32'd20, 32'd30);

    md_test("mul", EXE_CMD_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    alu_test("add_b2b", EXE_CMD_ADD, 32'd100, 32'd23, 32'd123);
    md_test("mul_ff", EXE_CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    md_test("div", EXE_CMD_DIV, 32'd100, 32'd7, 32'd14);
    md_test("rem", EXE_CMD_REM, 32'd100, 32'd7, 32'd2);
    md_test("div0", EXE_CMD_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF);
    md_test("rem0", EXE_CMD_REM, 32'd9, 32'd0, 32'd9);
    md_test("div_big", EXE_CMD_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    md_test("rem_big", EXE_CMD_REM, 32'hFFFF_FFFF, 32'h10, 32'hF);

    // Flush during RUN cycle 10
    set_in(EXE_CMD_MUL, 32'd7, 32'd9, 1'b1, 5'd4, 32'h200);
    #1;
    chk("flush.start_stall", 32'(Stall), 32'd1);
    for (int i = 0; i < 10; i++) tick;
    chk("flush.run_state", 32'(state_dbg), 32'(ST_RUN));
    Flush = 1'b1;
    #1;
    chk("flush.stall", 32'(Stall), 32'd0);
    tick;
    Flush = 1'b0;
    set_nop;
    chk("flush.wb", 32'(WB_EN_MEM), 32'd0);
    chk("flush.res", ALU_Res_MEM, 32'd0);
    chk("flush.state", 32'(state_dbg), 32'(ST_IDLE));
    md_test("mul_after_flush", EXE_CMD_MUL, 32'd2, 32'd3, 32'd6);

`ifdef EXE_SIGNED_MULDIV_EN
    md_test("divs", EXE_CMD_DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_test("rems", EXE_CMD_REMS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_test("divs_ovf", EXE_CMD_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_test("rems_ovf", EXE_CMD_REMS, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    md_test("divs0", EXE_CMD_DIVS, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    md_test("rems0", EXE_CMD_REMS, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
`else
    alu_test("cmd12", 6'd12, 32'd1, 32'd2, 32'd3);
    alu_test("cmd13", 6'd13, 32'd5, 32'd6, 32'd11);
`endif

    // Reset in the middle of a running DIV
    set_in(EXE_CMD_DIV, 32'd100, 32'd7, 1'b1, 5'd7, 32'h300);
    for (int i = 0; i < 6; i++) tick;
    chk("rst_mid.pre_stall", 32'(Stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid.stall", 32'(Stall), 32'd0);
    chk("rst_mid.state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_mid.wb", 32'(WB_EN_MEM), 32'd0);
    chk("rst_mid.res", ALU_Res_MEM, 32'd0);
    chk("rst_mid.pc", PC_MEM, 32'd0);
    chk("rst_mid.dst", 32'(Dst_MEM), 32'd0);
    set_in(EXE_CMD_ADD, 32'd3, 32'd4, 1'b1, 5'd2, 32'h44);
    #2;
    rst = 1'b1;
    tick;
    chk("rst_mid.add", ALU_Res_MEM, 32'd7);
    chk("rst_mid.add_wb", 32'(WB_EN_MEM), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
